simon_datapath: RTL and testbench

- Datapath half of the Simon game; sits directly downstream of the Simon controller and consumes its control strobes (clr/cnt count, clr/cnt index, w_en, read_Memory, set_level).
- Holds the latched difficulty level, the stored pattern sequence, the sequence length (count) and the replay/compare pointer (index).
- Returns the three status flags the controller branches on (is_legal, index_lt_count, input_eq_pattern).
- Drives the pattern LEDs.

---
 rtl/simon_datapath_pkg.sv | 17 +
 rtl/simon_datapath_if.sv | 31 +++
 rtl/simon_pattern_mem.sv | 25 ++
 rtl/simon_datapath.sv | 74 +++++++
 tb/tb_simon_datapath.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_datapath_pkg.sv
// Shared constants for the Simon game: pattern geometry, level encodings and LED source modes.
package simon_datapath_pkg;

    localparam int unsigned DEF_PATTERN_W = 4;
    localparam int unsigned DEF_ADDR_W    = 6;
    localparam int unsigned DEF_DEPTH     = 1 << DEF_ADDR_W;

    typedef enum logic {
        LEVEL_EASY = 1'b0,
        LEVEL_HARD = 1'b1
    } level_e;

    // LED source select, as driven by the controller on read_Memory.
    localparam logic LED_MODE_SWITCH = 1'b0;
    localparam logic LED_MODE_MEMORY = 1'b1;

endpackage

// File: rtl/simon_datapath_if.sv
// Controller <-> datapath link: control strobes toward the datapath, status flags and LEDs back.
interface simon_datapath_if #(
    parameter int unsigned PATTERN_W = simon_datapath_pkg::DEF_PATTERN_W
);
    logic                 level;
    logic [PATTERN_W-1:0] pattern;
    logic                 cnt_count;
    logic                 clr_count;
    logic                 cnt_index;
    logic                 clr_index;
    logic                 read_Memory;
    logic                 w_en;
    logic                 set_level;
    logic                 is_legal;
    logic                 index_lt_count;
    logic                 input_eq_pattern;
    logic [PATTERN_W-1:0] pattern_leds;

    modport master (
        output level, pattern, cnt_count, clr_count, cnt_index, clr_index,
               read_Memory, w_en, set_level,
        input  is_legal, index_lt_count, input_eq_pattern, pattern_leds
    );

    modport slave (
        input  level, pattern, cnt_count, clr_count, cnt_index, clr_index,
               read_Memory, w_en, set_level,
        output is_legal, index_lt_count, input_eq_pattern, pattern_leds
    );

endinterface

// File: rtl/simon_pattern_mem.sv
// Pattern sequence store: synchronous write, asynchronous read, contents not reset.
module simon_pattern_mem #(
    parameter int unsigned PATTERN_W = simon_datapath_pkg::DEF_PATTERN_W,
    parameter int unsigned ADDR_W    = simon_datapath_pkg::DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [PATTERN_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [PATTERN_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [PATTERN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: level register, sequence count, replay index, pattern memory and status flags.
module simon_datapath
    import simon_datapath_pkg::*;
#(
    parameter int unsigned PATTERN_W = DEF_PATTERN_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    simon_datapath_if.slave   bus
);
    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]      count;
    logic [ADDR_W:0]      index;
    level_e               level_r;
    logic                 count_full;
    logic                 index_end;
    logic                 mem_we;
    logic [PATTERN_W-1:0] mem_rdata;
    logic [PATTERN_W-1:0] rd_value;
    logic                 one_hot;

    assign count_full = (count == DEPTH_V);
    assign index_end  = (index == DEPTH_V);
    // Reset also blocks the write so a mid-game reset leaves no stray entry behind.
    assign mem_we     = bus.w_en && !count_full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            index   <= '0;
            level_r <= LEVEL_EASY;
        end else begin
            if (bus.clr_count) begin
                count <= '0;
            end else if (bus.cnt_count && !count_full) begin
                count <= count + 1'b1;
            end
            if (bus.clr_index) begin
                index <= '0;
            end else if (bus.cnt_index && !index_end) begin
                index <= index + 1'b1;
            end
            if (bus.set_level) begin
                level_r <= level_e'(bus.level);
            end
        end
    end

    simon_pattern_mem #(
        .PATTERN_W (PATTERN_W),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (count[ADDR_W-1:0]),
        .wdata (bus.pattern),
        .raddr (index[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_value = index_end ? '0 : mem_rdata;
        one_hot  = (bus.pattern != '0) && ((bus.pattern & (bus.pattern - 1'b1)) == '0);

        bus.is_legal         = !count_full && ((level_r == LEVEL_HARD) || one_hot);
        bus.index_lt_count   = (index < count);
        bus.input_eq_pattern = (bus.pattern == rd_value);
        bus.pattern_leds     = (bus.read_Memory == LED_MODE_MEMORY) ? rd_value : bus.pattern;
    end

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath with a behavioural reference model checked every cycle.
module tb_simon_datapath;

    logic clk = 1'b0;
    logic rst;

    simon_datapath_if #(.PATTERN_W(4)) bus ();

    simon_datapath #(
        .PATTERN_W (4),
        .ADDR_W    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: sequence as an array, count/index as plain integers.
    logic [3:0] m_mem [64];
    bit         m_vld [64];
    int         m_cnt = 0;
    int         m_idx = 0;
    bit         m_lvl = 1'b0;
    bit         m_ok  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_idx = 0;
            m_lvl = 1'b0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            if (bus.w_en && m_cnt < 64) begin
                m_mem[m_cnt] = bus.pattern;
                m_vld[m_cnt] = 1'b1;
            end
            if (bus.set_level) m_lvl = bus.level;
            if (bus.clr_count) m_cnt = 0;
            else if (bus.cnt_count && m_cnt < 64) m_cnt = m_cnt + 1;
            if (bus.clr_index) m_idx = 0;
            else if (bus.cnt_index && m_idx < 64) m_idx = m_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            bit         known;
            logic [3:0] rv;
            known = (m_idx == 64) ? 1'b1 : m_vld[m_idx];
            rv    = (m_idx == 64) ? 4'd0 : m_mem[m_idx];
            chk("model is_legal", 32'(bus.is_legal),
                32'((m_cnt != 64) && (m_lvl || $countones(bus.pattern) == 1)));
            chk("model index_lt_count", 32'(bus.index_lt_count), 32'(m_idx < m_cnt));
            if (known) begin
                chk("model input_eq_pattern", 32'(bus.input_eq_pattern),
                    32'(bus.pattern == rv));
                chk("model pattern_leds", 32'(bus.pattern_leds),
                    32'(bus.read_Memory ? rv : bus.pattern));
            end else if (!bus.read_Memory) begin
                chk("model pattern_leds", 32'(bus.pattern_leds), 32'(bus.pattern));
            end
        end
    end

    // Advance one clock; one-cycle strobes drop afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.w_en      = 1'b0;
        bus.cnt_count = 1'b0;
        bus.clr_count = 1'b0;
        bus.cnt_index = 1'b0;
        bus.clr_index = 1'b0;
        bus.set_level = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        bus.level       = 1'b0;
        bus.pattern     = 4'b0000;
        bus.cnt_count   = 1'b0;
        bus.clr_count   = 1'b0;
        bus.cnt_index   = 1'b0;
        bus.clr_index   = 1'b0;
        bus.read_Memory = 1'b0;
        bus.w_en        = 1'b0;
        bus.set_level   = 1'b0;
        tick();

        // Reset state and level rules
        bus.pattern = 4'b0011;
        sample();
        chk("reset index_lt_count", 32'(bus.index_lt_count), 32'd0);
        chk("reset leds follow switches", 32'(bus.pattern_leds), 32'b0011);
        chk("reset easy two bits", 32'(bus.is_legal), 32'd0);
        bus.level = 1'b0; bus.set_level = 1'b1;
        tick();
        bus.pattern = 4'b0101;
        sample();
        chk("easy 0101", 32'(bus.is_legal), 32'd0);
        bus.pattern = 4'b0100;
        sample();
        chk("easy 0100", 32'(bus.is_legal), 32'd1);
        bus.level = 1'b1; bus.set_level = 1'b1;
        tick();
        bus.pattern = 4'b0101;
        sample();
        chk("hard 0101", 32'(bus.is_legal), 32'd1);
        bus.level = 1'b0; bus.set_level = 1'b1;
        tick();

        // Store three patterns and replay them
        bus.pattern = 4'b0001; bus.w_en = 1'b1; bus.cnt_count = 1'b1; tick();
        bus.pattern = 4'b0010; bus.w_en = 1'b1; bus.cnt_count = 1'b1; tick();
        bus.pattern = 4'b1000; bus.w_en = 1'b1; bus.cnt_count = 1'b1; tick();
        bus.clr_index = 1'b1; tick();
        bus.read_Memory = 1'b1;
        sample();
        chk("replay0 leds", 32'(bus.pattern_leds), 32'b0001);
        chk("replay0 lt", 32'(bus.index_lt_count), 32'd1);
        bus.cnt_index = 1'b1; tick();
        sample();
        chk("replay1 leds", 32'(bus.pattern_leds), 32'b0010);
        chk("replay1 lt", 32'(bus.index_lt_count), 32'd1);
        bus.cnt_index = 1'b1; tick();
        sample();
        chk("replay2 leds", 32'(bus.pattern_leds), 32'b1000);
        chk("replay2 lt", 32'(bus.index_lt_count), 32'd1);
        bus.cnt_index = 1'b1; tick();
        sample();
        chk("replay3 lt", 32'(bus.index_lt_count), 32'd0);

        // Player input compare
        bus.read_Memory = 1'b0;
        bus.clr_index = 1'b1; tick();
        bus.pattern = 4'b0001;
        sample();
        chk("eq idx0 0001", 32'(bus.input_eq_pattern), 32'd1);
        bus.pattern = 4'b0010;
        sample();
        chk("eq idx0 0010", 32'(bus.input_eq_pattern), 32'd0);
        bus.cnt_index = 1'b1; tick();
        sample();
        chk("eq idx1 0010", 32'(bus.input_eq_pattern), 32'd1);

        // Fill memory to capacity
        bus.clr_count = 1'b1; tick();
        for (int k = 0; k < 64; k++) begin
            bus.pattern = 4'(1 << (k % 4)); bus.w_en = 1'b1; bus.cnt_count = 1'b1;
            tick();
        end
        bus.pattern = 4'b0001;
        sample();
        chk("full easy 0001", 32'(bus.is_legal), 32'd0);
        bus.pattern = 4'b1111; bus.w_en = 1'b1; bus.cnt_count = 1'b1; tick();
        bus.clr_index = 1'b1; tick();
        bus.read_Memory = 1'b1;
        sample();
        chk("full still illegal", 32'(bus.is_legal), 32'd0);
        chk("mem0 kept", 32'(bus.pattern_leds), 32'b0001);
        for (int k = 0; k < 63; k++) begin
            bus.cnt_index = 1'b1; tick();
        end
        sample();
        chk("mem63", 32'(bus.pattern_leds), 32'b1000);
        bus.cnt_index = 1'b1; tick();
        bus.pattern = 4'b0000;
        sample();
        chk("index end leds", 32'(bus.pattern_leds), 32'd0);
        chk("index end lt", 32'(bus.index_lt_count), 32'd0);
        chk("index end eq zero", 32'(bus.input_eq_pattern), 32'd1);
        bus.cnt_index = 1'b1; tick();
        bus.clr_index = 1'b1; bus.cnt_index = 1'b1; tick();
        sample();
        chk("index saturated then cleared", 32'(bus.pattern_leds), 32'b0001);
        bus.read_Memory = 1'b0;

        // Clear wins over count
        bus.clr_count = 1'b1; tick();
        for (int k = 0; k < 5; k++) begin
            bus.pattern = 4'b0100; bus.w_en = 1'b1; bus.cnt_count = 1'b1; tick();
        end
        bus.clr_index = 1'b1; tick();
        sample();
        chk("count5 lt", 32'(bus.index_lt_count), 32'd1);
        bus.clr_count = 1'b1; bus.cnt_count = 1'b1; tick();
        bus.pattern = 4'b0001;
        sample();
        chk("count cleared lt", 32'(bus.index_lt_count), 32'd0);
        chk("count cleared legal", 32'(bus.is_legal), 32'd1);
        bus.cnt_count = 1'b1; tick();
        bus.cnt_index = 1'b1; tick();
        bus.cnt_index = 1'b1; tick();
        bus.clr_index = 1'b1; bus.cnt_index = 1'b1; tick();
        sample();
        chk("index cleared lt", 32'(bus.index_lt_count), 32'd1);

        // Reset mid-replay
        bus.clr_count = 1'b1; tick();
        for (int k = 0; k < 3; k++) begin
            bus.pattern = 4'b0010; bus.w_en = 1'b1; bus.cnt_count = 1'b1; tick();
        end
        bus.clr_index = 1'b1; tick();
        bus.cnt_index = 1'b1; tick();
        bus.cnt_index = 1'b1; tick();
        bus.level = 1'b1; bus.set_level = 1'b1; tick();
        bus.pattern = 4'b0110;
        sample();
        chk("pre-reset lt", 32'(bus.index_lt_count), 32'd1);
        chk("pre-reset hard", 32'(bus.is_legal), 32'd1);
        rst = 1'b1; tick();
        sample();
        chk("post-reset lt", 32'(bus.index_lt_count), 32'd0);
        chk("post-reset leds", 32'(bus.pattern_leds), 32'b0110);
        chk("post-reset level easy", 32'(bus.is_legal), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
